smart_lighting_zones: RTL and testbench

//   Multi-zone motion-lighting controller. Each of N_ZONES zones runs its own

---
 rtl/smart_lighting_zones_if.sv | 23 ++
 rtl/smart_lighting_zones.sv | 111 +++++++++++
 tb/tb_smart_lighting_zones.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/smart_lighting_zones_if.sv
// rtl/smart_lighting_zones_if.sv - sensor/switch inputs and lamp outputs of the zone controller
interface smart_lighting_zones_if #(
  parameter int N_ZONES = 4
);
  localparam int AC_W = $clog2(N_ZONES + 1);

  logic [N_ZONES-1:0] motion;
  logic [N_ZONES-1:0] force_on;
  logic [N_ZONES-1:0] force_off;
  logic [N_ZONES-1:0] light_on;
  logic [N_ZONES-1:0] light_dim;
  logic [AC_W-1:0]    active_count;

  modport master (
    output motion, force_on, force_off,
    input  light_on, light_dim, active_count
  );

  modport slave (
    input  motion, force_on, force_off,
    output light_on, light_dim, active_count
  );
endinterface

// File: rtl/smart_lighting_zones.sv
// rtl/smart_lighting_zones.sv - per-zone motion lighting FSMs with hold-off, dim warning and overrides
module smart_lighting_zones #(
  parameter int N_ZONES     = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int DIM_CYCLES  = 100,
  localparam int CNT_W      = $clog2(HOLD_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  smart_lighting_zones_if.slave  bus
);

  localparam int AC_W = $clog2(N_ZONES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIM_LIM   = CNT_W'(DIM_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ARMED = 2'b01,
    ST_ON    = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  state_e           state_q [N_ZONES];
  state_e           state_d [N_ZONES];
  logic [CNT_W-1:0] cnt_q   [N_ZONES];
  logic [CNT_W-1:0] cnt_d   [N_ZONES];

  logic [N_ZONES-1:0] on_vec;
  logic [N_ZONES-1:0] dim_vec;
  logic [AC_W-1:0]    act_cnt;

  // Overrides win over motion/timer; every entry into OFF clears the counter.
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.force_off[i]) begin
        state_d[i] = ST_OFF;
        cnt_d[i]   = '0;
      end else if (bus.force_on[i]) begin
        state_d[i] = ST_ON;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            if (bus.motion[i]) state_d[i] = ST_ARMED;
          end
          ST_ARMED: begin
            if (bus.motion[i]) begin
              state_d[i] = ST_ON;
            end else begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
            end
          end
          ST_ON: begin
            if (!bus.motion[i]) begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = HOLD_LOAD;
            end
          end
          ST_HOLD: begin
            if (bus.motion[i]) begin
              state_d[i] = ST_ON;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] - 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Moore decodes only: no combinational path from the inputs to the lamps.
  always_comb begin
    on_vec  = '0;
    dim_vec = '0;
    act_cnt = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      on_vec[i]  = (state_q[i] == ST_ON) || (state_q[i] == ST_HOLD);
      dim_vec[i] = (state_q[i] == ST_HOLD) && (cnt_q[i] < DIM_LIM);
      act_cnt    = act_cnt + AC_W'(on_vec[i]);
    end
  end

  assign bus.light_on     = on_vec;
  assign bus.light_dim    = dim_vec;
  assign bus.active_count = act_cnt;

endmodule

// File: tb/tb_smart_lighting_zones.sv
// tb/tb_smart_lighting_zones.sv - directed and random checks against a quiet-cycle counting model
module tb_smart_lighting_zones;

  localparam int N = 4;
  localparam int H = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model: lit flag, consecutive quiet edges since lit, and pending first motion sample.
  int   m_lit   [N];
  int   m_quiet [N];
  int   m_armed [N];

  smart_lighting_zones_if #(.N_ZONES(N)) bus ();

  smart_lighting_zones #(
    .N_ZONES(N), .HOLD_CYCLES(H), .DIM_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int z = 0; z < N; z++) begin
      m_lit[z] = 0; m_quiet[z] = 0; m_armed[z] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] m, input logic [N-1:0] fo, input logic [N-1:0] ff);
    for (int z = 0; z < N; z++) begin
      if (ff[z]) begin
        m_lit[z] = 0; m_quiet[z] = 0; m_armed[z] = 0;
      end else if (fo[z]) begin
        m_lit[z] = 1; m_quiet[z] = 0; m_armed[z] = 0;
      end else if (m_lit[z] != 0) begin
        if (m[z]) m_quiet[z] = 0;
        else begin
          m_quiet[z]++;
          if (m_quiet[z] > H) begin m_lit[z] = 0; m_quiet[z] = 0; end
        end
      end else if (m[z] && m_armed[z] != 0) begin
        m_lit[z] = 1; m_quiet[z] = 0; m_armed[z] = 0;
      end else begin
        m_armed[z] = m[z] ? 1 : 0;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N-1:0] e_on, e_dim;
    logic [2:0]   e_cnt;
    e_on = '0; e_dim = '0; e_cnt = '0;
    for (int z = 0; z < N; z++) begin
      e_on[z]  = (m_lit[z] != 0);
      e_dim[z] = (m_lit[z] != 0) && (m_quiet[z] > 0) && ((H - m_quiet[z]) < D);
      e_cnt    = e_cnt + 3'(e_on[z]);
    end
    checks++;
    assert (bus.light_on === e_on) else begin
      errors++; $error("FAIL %s light_on got %b exp %b", tag, bus.light_on, e_on);
    end
    checks++;
    assert (bus.light_dim === e_dim) else begin
      errors++; $error("FAIL %s light_dim got %b exp %b", tag, bus.light_dim, e_dim);
    end
    checks++;
    assert (bus.active_count === e_cnt) else begin
      errors++; $error("FAIL %s active_count got %0d exp %0d", tag, bus.active_count, e_cnt);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] m, input logic [N-1:0] fo, input logic [N-1:0] ff, input string tag);
    bus.motion = m; bus.force_on = fo; bus.force_off = ff;
    @(posedge clk);
    model_edge(m, fo, ff);
    #1;
    check(tag);
  endtask

  initial begin
    logic [N-1:0] rm, rfo, rff;
    bus.motion = '0; bus.force_on = '0; bus.force_off = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single-cycle motion rejected
    step(4'b0001, 4'b0000, 4'b0000, "t1_arm");
    step(4'b0000, 4'b0000, 4'b0000, "t1_drop");
    check_val("t1_never_lit", int'(bus.light_on[0]), 0);

    // 2: confirm, full hold with dim tail
    step(4'b0001, 4'b0000, 4'b0000, "t2_m1");
    step(4'b0001, 4'b0000, 4'b0000, "t2_m2");
    check_val("t2_lit", int'(bus.light_on[0]), 1);
    for (int i = 0; i < H + 2; i++) step(4'b0000, 4'b0000, 4'b0000, "t2_hold");
    check_val("t2_off", int'(bus.light_on[0]), 0);

    // 3: motion returns at counter 4, then a fresh full hold
    step(4'b0001, 4'b0000, 4'b0000, "t3_m1");
    step(4'b0001, 4'b0000, 4'b0000, "t3_m2");
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 4'b0000, "t3_hold_a");
    step(4'b0001, 4'b0000, 4'b0000, "t3_reon");
    for (int i = 0; i < H + 2; i++) step(4'b0000, 4'b0000, 4'b0000, "t3_hold_b");

    // 4: force_off dominates force_on
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0100, 4'b0100, "t4_both");
    check_val("t4_off", int'(bus.light_on[2]), 0);
    step(4'b0000, 4'b0100, 4'b0000, "t4_fon");
    check_val("t4_on", int'(bus.light_on[2]), 1);
    for (int i = 0; i < H + 2; i++) step(4'b0000, 4'b0000, 4'b0000, "t4_hold");

    // 5: active_count tracks lit zones
    step(4'b1011, 4'b0000, 4'b0000, "t5_m1");
    step(4'b1011, 4'b0000, 4'b0000, "t5_m2");
    check_val("t5_count3", int'(bus.active_count), 3);
    for (int i = 0; i < H + 1; i++) step(4'b1001, 4'b0000, 4'b0000, "t5_z1_hold");
    check_val("t5_count2", int'(bus.active_count), 2);
    step(4'b0000, 4'b0000, 4'b1111, "t5_clear");

    // 6: async reset in the middle of a hold (counter 5)
    step(4'b0001, 4'b0000, 4'b0000, "t6_m1");
    step(4'b0001, 4'b0000, 4'b0000, "t6_m2");
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 4'b0000, "t6_hold");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b0001, 4'b0000, 4'b0000, "t6_rearm");
    check_val("t6_not_yet", int'(bus.light_on[0]), 0);
    step(4'b0001, 4'b0000, 4'b0000, "t6_relit");

    // Random traffic with rare overrides
    for (int i = 0; i < 400; i++) begin
      for (int z = 0; z < N; z++) rm[z] = ($urandom_range(0, 2) == 0);
      rfo = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      rff = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0000;
      step(rm, rfo, rff, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
